// File: rtl/hap_isa_pkg.sv
// HAP ISA definitions shared by the branch controller and the decode stage.
package hap_isa_pkg;

   localparam logic [4:0] OP_LT   = 5'b01011;
   localparam logic [4:0] OP_GT   = 5'b01100;
   localparam logic [4:0] OP_EQ   = 5'b01101;
   localparam logic [4:0] OP_GTE  = 5'b01110;
   localparam logic [4:0] OP_LTE  = 5'b01111;
   localparam logic [4:0] OP_NE   = 5'b10000;
   localparam logic [4:0] OP_JMP  = 5'b10001;
   localparam logic [4:0] OP_BRT  = 5'b10010;
   localparam logic [4:0] OP_BRF  = 5'b10011;
   localparam logic [4:0] OP_HALT = 5'b11111;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HALT  = 2'd2
   } ctrl_state_e;

   // True for any opcode that writes the condition flag.
   function automatic logic is_cmp(input logic [4:0] op);
      return (op >= OP_LT) && (op <= OP_NE);
   endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational opcode classification and branch decision against the flag.
module branch_resolve
   import hap_isa_pkg::*;
(
   input  logic [4:0] opcode,
   input  logic       flag,
   output logic       taken,
   output logic       cmp_op,
   output logic       halt_op
);

   // Decode the opcode class and whether a branch would be taken.
   always_comb begin
      taken   = 1'b0;
      cmp_op  = is_cmp(opcode);
      halt_op = (opcode == OP_HALT);
      case (opcode)
         OP_JMP:  taken = 1'b1;
         OP_BRT:  taken = flag;
         OP_BRF:  taken = ~flag;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/cmp_branch_ctrl.sv
// Compare-flag latch, branch resolution, PC ownership and flush sequencing.
module cmp_branch_ctrl
   import hap_isa_pkg::*;
#(
   parameter int unsigned PC_W      = 8,
   parameter int unsigned FLUSH_CYC = 2,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            instr_valid_i,
   output logic            instr_ready_o,
   input  logic [4:0]      opcode_i,
   input  logic [PC_W-1:0] target_i,
   input  logic [2:0]      cmp_rd_i,
   output logic [PC_W-1:0] pc_o,
   output logic            flag_o,
   output logic            flush_o,
   output logic            halted_o,
   output logic [7:0]      taken_cnt_o
);

   if (FLUSH_CYC < 1 || FLUSH_CYC > 7) begin : g_bad_flush_cyc
      $error("cmp_branch_ctrl: FLUSH_CYC must be in 1..7");
   end

   ctrl_state_e     state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            flag_q, flag_d;
   logic            flush_q, flush_d;
   logic            halted_q, halted_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [2:0]      fcnt_q, fcnt_d;

   logic            taken, cmp_op, halt_op;

   branch_resolve u_resolve (
      .opcode  (opcode_i),
      .flag    (flag_q),
      .taken   (taken),
      .cmp_op  (cmp_op),
      .halt_op (halt_op)
   );

   // State and architectural registers; reset wins at any time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_PC;
         flag_q   <= 1'b0;
         flush_q  <= 1'b0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
         fcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         flag_q   <= flag_d;
         flush_q  <= flush_d;
         halted_q <= halted_d;
         cnt_q    <= cnt_d;
         fcnt_q   <= fcnt_d;
      end
   end

   // Next-state logic: accept in RUN, count down in FLUSH, park in HALT.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      flag_d   = flag_q;
      flush_d  = flush_q;
      halted_d = halted_q;
      cnt_d    = cnt_q;
      fcnt_d   = fcnt_q;
      case (state_q)
         ST_RUN: begin
            if (instr_valid_i) begin
               if (cmp_op) flag_d = |cmp_rd_i;
               if (halt_op) begin
                  state_d  = ST_HALT;
                  halted_d = 1'b1;
               end else if (taken) begin
                  pc_d    = target_i;
                  cnt_d   = cnt_q + 8'd1;
                  flush_d = 1'b1;
                  state_d = ST_FLUSH;
                  fcnt_d  = 3'(FLUSH_CYC - 1);
               end else begin
                  pc_d = pc_q + PC_W'(1);
               end
            end
         end
         ST_FLUSH: begin
            if (fcnt_q == '0) begin
               state_d = ST_RUN;
               flush_d = 1'b0;
            end else begin
               fcnt_d = fcnt_q - 3'd1;
            end
         end
         ST_HALT: begin
            flush_d = 1'b0;
         end
         default: begin
            state_d = ST_RUN;
            flush_d = 1'b0;
         end
      endcase
   end

   assign instr_ready_o = (state_q == ST_RUN);
   assign pc_o          = pc_q;
   assign flag_o        = flag_q;
   assign flush_o       = flush_q;
   assign halted_o      = halted_q;
   assign taken_cnt_o   = cnt_q;

endmodule

// File: tb/tb_cmp_branch_ctrl.sv
// Directed testbench for cmp_branch_ctrl with hand-computed expectations.
module tb_cmp_branch_ctrl;

   localparam logic [4:0] LT = 5'b01011, GT = 5'b01100, EQ = 5'b01101;
   localparam logic [4:0] LTE = 5'b01111, NE = 5'b10000;
   localparam logic [4:0] JMP = 5'b10001, BRT = 5'b10010, BRF = 5'b10011;
   localparam logic [4:0] HLT = 5'b11111, NOP = 5'b00000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       instr_valid_i = 1'b0;
   logic       instr_ready_o;
   logic [4:0] opcode_i = '0;
   logic [7:0] target_i = '0;
   logic [2:0] cmp_rd_i = '0;
   logic [7:0] pc_o;
   logic       flag_o, flush_o, halted_o;
   logic [7:0] taken_cnt_o;

   int checks = 0;
   int errors = 0;

   cmp_branch_ctrl #(.PC_W(8), .FLUSH_CYC(2), .RESET_PC(8'h00)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr_valid_i (instr_valid_i),
      .instr_ready_o (instr_ready_o),
      .opcode_i      (opcode_i),
      .target_i      (target_i),
      .cmp_rd_i      (cmp_rd_i),
      .pc_o          (pc_o),
      .flag_o        (flag_o),
      .flush_o       (flush_o),
      .halted_o      (halted_o),
      .taken_cnt_o   (taken_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for exactly one edge, then drop valid.
   task automatic issue(input logic [4:0] op, input logic [7:0] tgt, input logic [2:0] rd);
      instr_valid_i = 1'b1;
      opcode_i = op;
      target_i = tgt;
      cmp_rd_i = rd;
      step();
      instr_valid_i = 1'b0;
      opcode_i = NOP;
      cmp_rd_i = '0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_pc"}, pc_o, 8'h00);
      check({tag, "_flag"}, flag_o, 1'b0);
      check({tag, "_flush"}, flush_o, 1'b0);
      check({tag, "_halted"}, halted_o, 1'b0);
      check({tag, "_cnt"}, taken_cnt_o, 8'h00);
      check({tag, "_ready"}, instr_ready_o, 1'b1);
   endtask

   initial begin
      #3;
      check_reset_values("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // 1: LT sets flag, BRT taken, two-cycle flush with held JMP
      issue(LT, 8'h00, 3'd1);
      check("lt_flag", flag_o, 1'b1);
      check("lt_pc", pc_o, 8'h01);
      instr_valid_i = 1'b1; opcode_i = BRT; target_i = 8'h40;
      step();
      check("brt_pc", pc_o, 8'h40);
      check("brt_flush1", flush_o, 1'b1);
      check("brt_ready1", instr_ready_o, 1'b0);
      check("brt_cnt", taken_cnt_o, 8'd1);
      // 5: JMP held during flush must not be consumed
      opcode_i = JMP; target_i = 8'h80;
      step();
      check("hold_pc1", pc_o, 8'h40);
      check("brt_flush2", flush_o, 1'b1);
      check("brt_ready2", instr_ready_o, 1'b0);
      step();
      check("hold_pc2", pc_o, 8'h40);
      check("flush_end", flush_o, 1'b0);
      check("ready_back", instr_ready_o, 1'b1);
      step();
      instr_valid_i = 1'b0; opcode_i = NOP;
      check("held_jmp_pc", pc_o, 8'h80);
      check("held_jmp_cnt", taken_cnt_o, 8'd2);
      step(); step();

      // 2: GT clears flag, BRT not taken, BRF taken
      issue(GT, 8'h00, 3'd0);
      check("gt_flag", flag_o, 1'b0);
      check("gt_pc", pc_o, 8'h81);
      issue(BRT, 8'h20, 3'd0);
      check("brt_nt_pc", pc_o, 8'h82);
      check("brt_nt_flush", flush_o, 1'b0);
      check("brt_nt_cnt", taken_cnt_o, 8'd2);
      issue(BRF, 8'h20, 3'd0);
      check("brf_pc", pc_o, 8'h20);
      check("brf_cnt", taken_cnt_o, 8'd3);
      check("brf_flush", flush_o, 1'b1);
      step(); step();

      // 3: back-to-back EQ then BRT uses the new flag
      issue(EQ, 8'h00, 3'd1);
      check("eq_pc", pc_o, 8'h21);
      issue(BRT, 8'h30, 3'd0);
      check("eq_brt_pc", pc_o, 8'h30);
      check("eq_brt_cnt", taken_cnt_o, 8'd4);
      step(); step();
      issue(NE, 8'h00, 3'd4);
      check("ne_flag", flag_o, 1'b1);
      issue(LTE, 8'h00, 3'd0);
      check("lte_flag", flag_o, 1'b0);
      issue(NOP, 8'h00, 3'd1);
      check("nop_rd_flag", flag_o, 1'b0);
      check("nop_pc", pc_o, 8'h33);
      issue(BRT, 8'h50, 3'd7);
      check("brt_own_rd_pc", pc_o, 8'h34);
      check("brt_own_rd_flag", flag_o, 1'b0);
      check("brt_own_rd_flush", flush_o, 1'b0);

      // 4: PC wraps at FF
      issue(JMP, 8'hFF, 3'd0);
      step(); step();
      check("jmp_ff_pc", pc_o, 8'hFF);
      issue(NOP, 8'h00, 3'd0);
      check("pc_wrap", pc_o, 8'h00);

      // 4: taken counter wraps after 256 taken branches from reset
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 255; i++) begin
         issue(JMP, 8'(i), 3'd0);
         step(); step();
      end
      check("cnt_255", taken_cnt_o, 8'd255);
      issue(JMP, 8'h10, 3'd0);
      check("cnt_wrap", taken_cnt_o, 8'd0);

      // 6: asynchronous reset in the middle of a flush
      check("pre_rst_flush", flush_o, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("rst_flush");
      @(negedge clk);
      rst_n = 1'b1;

      // 6: HALT is terminal until reset
      issue(NOP, 8'h00, 3'd0);
      issue(NOP, 8'h00, 3'd0);
      issue(HLT, 8'h00, 3'd0);
      check("halt_pc", pc_o, 8'h02);
      check("halt_flag", halted_o, 1'b1);
      check("halt_ready", instr_ready_o, 1'b0);
      instr_valid_i = 1'b1; opcode_i = JMP; target_i = 8'h77;
      step(); step(); step();
      check("halt_hold_pc", pc_o, 8'h02);
      check("halt_hold_ready", instr_ready_o, 1'b0);
      check("halt_hold_flush", flush_o, 1'b0);
      check("halt_hold_cnt", taken_cnt_o, 8'd0);
      instr_valid_i = 1'b0; opcode_i = NOP;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("rst_halt");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("post_rst_ready", instr_ready_o, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
